// File: rtl/instruction_fetch_controller.sv
// Instruction fetch front end: sequential PC generation, a small prefetch FIFO
// holding {word, pc} pairs, and branch redirect with full flush.
module instruction_fetch_controller #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     branch_taken,
    input  logic [ADDR_W-1:0]        branch_target,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [31:0]              rom_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_out,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [31:0]       buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic              full;
    logic              push;
    logic              pop;

    assign rom_addr   = fetch_pc;
    assign fifo_count = count;
    assign inst_valid = (count != '0);
    assign inst_out   = buf_data[head];
    assign inst_pc    = buf_pc[head];

    always_comb begin
        // FETCH implies not full and FULL implies full; only IDLE needs the count.
        full       = (state == FULL) || ((state == IDLE) && (count == CW'(DEPTH)));
        pop        = inst_valid && inst_ready;
        push       = enable && !branch_taken && (!full || pop);
        count_next = count + CW'(push) - CW'(pop);
        if (!enable)
            state_next = IDLE;
        else if (count_next == CW'(DEPTH))
            state_next = FULL;
        else
            state_next = FETCH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (branch_taken) begin
            state    <= enable ? FETCH : IDLE;
            fetch_pc <= {branch_target[ADDR_W-1:2], 2'b00};
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (push) begin
                buf_data[tail] <= rom_data;
                buf_pc[tail]   <= fetch_pc;
                tail           <= tail + PW'(1);
                fetch_pc       <= fetch_pc + ADDR_W'(4);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count_next;
            state <= state_next;
        end
    end
endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001: The block SHALL have parameter ADDR_W, default 9, byte-address width of the instruction memory.
REQ-002: The block SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-003: The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004: The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005: The block SHALL have port enable  input  1  fetch enable; 0 suspends new fetches.
REQ-006: The block SHALL have port branch_taken  input  1  redirect request, one-cycle pulse.
REQ-007: The block SHALL have port branch_target  input  ADDR_W  redirect byte address.
REQ-008: The block SHALL have port rom_addr  output  ADDR_W  address to instruction memory A.
REQ-009: The block SHALL have port rom_data  input  32  instruction word from memory I (combinational, same-cycle).
REQ-010: The block SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-011: The block SHALL have port inst_ready  input  1  consumer accepts head this cycle.
REQ-012: The block SHALL have port inst_out  output  32  head instruction word.
REQ-013: The block SHALL have port inst_pc  output  ADDR_W  byte address of the head instruction.
REQ-014: The block SHALL have port fifo_count  output  clog2(DEPTH)+1  occupied buffer entries.

Function
REQ-015: rom_addr SHALL equal the internal fetch_pc register combinationally.
REQ-016: pop SHALL occur when inst_valid=1 and inst_ready=1; inst_out/inst_pc SHALL change only on pop, push into empty buffer, or flush.
REQ-017: push SHALL occur when enable=1, branch_taken=0, and (fifo_count<DEPTH or pop); push stores {rom_data, fetch_pc} at tail and sets fetch_pc<=fetch_pc+4.
REQ-018: fetch_pc increment SHALL be modulo 2^ADDR_W (508+4 -> 0 for ADDR_W=9).
REQ-019: Simultaneous push and pop on a full buffer SHALL keep fifo_count at DEPTH with no data loss.
REQ-020: branch_taken=1 SHALL take priority over push and pop: buffer flushed (fifo_count<=0, inst_valid<=0), fetch_pc<={branch_target[ADDR_W-1:2],2'b00}; any handshake that cycle is discarded.
REQ-021: First instruction at a redirect target SHALL be pushed the cycle after branch_taken and be valid at the output one cycle after that push edge.
REQ-022: The block SHALL implement state machine IDLE/FETCH/FULL: IDLE when enable=0; FETCH when enable=1 and fifo_count<DEPTH; FULL when enable=1 and fifo_count=DEPTH; state is registered from next-cycle conditions; branch_taken forces FETCH if enable=1, else IDLE.
REQ-023: In IDLE the buffer SHALL continue draining via pop; fetch_pc SHALL hold.
REQ-024: In FULL with inst_ready=0, fetch_pc and buffer SHALL hold; rom_addr stays on the next unfetched address.
REQ-025: inst_valid SHALL equal (fifo_count!=0); fifo_count SHALL never exceed DEPTH or underflow.
REQ-026: Push/pop latency: word at rom_addr in cycle N SHALL appear on inst_out in cycle N+1 if the buffer was empty.

Reset
REQ-027: reset_n=0 SHALL asynchronously force fetch_pc=0, fifo_count=0, inst_valid=0, inst_out=0, inst_pc=0, state=IDLE, regardless of clk.
REQ-028: Reset asserted mid-operation (buffer non-empty, branch pending) SHALL discard all buffered entries and any pending redirect.
REQ-029: After reset_n deassertion with enable=1, the first push (address 0) SHALL occur on the first rising clk edge.

Verification
REQ-030: Reset release, enable=1, inst_ready=1 held -> inst_pc sequence 0,4,8,12 on consecutive cycles, inst_out matching memory words.
REQ-031: enable=1, inst_ready=0 for 5 cycles -> fifo_count 1,2,2,2,2, rom_addr holds 8, state FULL; then inst_ready=1 -> inst_pc 0,4,8 with no gap.
REQ-032: branch_taken=1, branch_target=0x41 while fifo_count=2 -> next cycle fifo_count=0, inst_valid=0, rom_addr=0x40; following cycle inst_pc=0x40.
REQ-033: branch_target=0x1FC, free-running -> inst_pc 0x1FC then 0x000 (wrap).
REQ-034: enable dropped with fifo_count=2, inst_ready=1 -> two pops then inst_valid=0, rom_addr constant, state IDLE.
REQ-035: reset_n pulsed low between clk edges with fifo_count=2 -> outputs zero immediately, before next clk edge.
